// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
//   Recovers a 4-digit BCD value by watching a multiplexed, active-low
//   7-segment display bus. The bus is asynchronous to clk_osc.
//   Each digit is captured once its {anode, eseg} pair has held steady.
//   A frame is published once all four positions have been seen.
//
// Ports
//   clk_osc      : sole clock, rising edge
//   reset        : asynchronous, active-high
//   anode[3:0]   : scanned digit select, active-low (asynchronous)
//   eseg[6:0]    : segment drive, active-low, bit0=a .. bit6=g (asynchronous)
//   digits[15:0] : last complete frame, BCD nibbles [15:12]..[3:0]
//   digit_valid  : per nibble, 1 = decimal glyph decoded
//   frame_valid  : digits holds a complete, non-stale frame
//   frame_strobe : one-cycle pulse when digits updates
//   bad_code     : one-cycle pulse on capture of an undefined pattern
//   onehot_err   : one-cycle pulse when a stable anode has >1 low bit
//   alarm_lit    : last frame had every segment lit on all four digits
//   stale        : one-cycle pulse when a partial frame times out
module seg_scan_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int TIMEOUT       = 1048576
) (
    input  logic        clk_osc,
    input  logic        reset,
    input  logic [3:0]  anode,
    input  logic [6:0]  eseg,
    output logic [15:0] digits,
    output logic [3:0]  digit_valid,
    output logic        frame_valid,
    output logic        frame_strobe,
    output logic        bad_code,
    output logic        onehot_err,
    output logic        alarm_lit,
    output logic        stale
);

    localparam int CW = $clog2(STABLE_CYCLES);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] CNT_PRE  = CW'(STABLE_CYCLES - 2);
    localparam logic [CW-1:0] CNT_CAP  = CW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] IDLE_PRE = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] IDLE_MAX = TW'(TIMEOUT);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_COMMIT  = 2'd2;

    // Two-flop synchronizers, plus the previous synchronized pair.
    logic [3:0] anode_m, anode_s, anode_p;
    logic [6:0] eseg_m, eseg_s, eseg_p;

    logic [CW-1:0] stab_cnt;
    logic [TW-1:0] idle_cnt;
    logic [1:0]    state;
    logic [3:0]    mask;
    logic [15:0]   shadow_nib;
    logic [3:0]    shadow_val;
    logic [3:0]    shadow_on;

    logic       pair_same;
    logic       event_fire;
    logic [3:0] pos_bit;
    logic       anode_multi;
    logic       capture;
    logic       timeout_evt;
    logic [3:0] mask_or;
    logic [6:0] seg_on;
    logic [3:0] dec_nib;
    logic       dec_val;
    logic       dec_bad;

    always_ff @(posedge clk_osc or posedge reset) begin
        if (reset) begin
            anode_m <= '1;
            anode_s <= '1;
            anode_p <= '1;
            eseg_m  <= '1;
            eseg_s  <= '1;
            eseg_p  <= '1;
        end else begin
            anode_m <= anode;
            anode_s <= anode_m;
            anode_p <= anode_s;
            eseg_m  <= eseg;
            eseg_s  <= eseg_m;
            eseg_p  <= eseg_s;
        end
    end

    assign pair_same = (anode_s == anode_p) && (eseg_s == eseg_p);
    // Fires on the single cycle the counter steps up to STABLE_CYCLES-1.
    // The counter saturates there, so one steady pair fires exactly once.
    assign event_fire = pair_same && (stab_cnt == CNT_PRE);

    always_ff @(posedge clk_osc or posedge reset) begin
        if (reset)
            stab_cnt <= '0;
        else if (!pair_same)
            stab_cnt <= '0;
        else if (stab_cnt != CNT_CAP)
            stab_cnt <= stab_cnt + 1'b1;
    end

    always_comb begin
        pos_bit = '0;
        case (anode_s)
            4'b0111: pos_bit = 4'b0001;
            4'b1110: pos_bit = 4'b0010;
            4'b1101: pos_bit = 4'b0100;
            4'b1011: pos_bit = 4'b1000;
            default: pos_bit = '0;
        endcase
    end

    // Anything that is neither a single low bit nor all-high has two or more low bits.
    assign anode_multi = (pos_bit == 4'b0000) && (anode_s != 4'b1111);
    assign capture     = event_fire && (pos_bit != 4'b0000);
    assign mask_or     = mask | pos_bit;
    assign seg_on      = ~eseg_s;

    always_comb begin
        dec_nib = 4'hE;
        dec_val = 1'b0;
        dec_bad = 1'b0;
        case (seg_on)
            7'h3F: begin dec_nib = 4'd0; dec_val = 1'b1; end
            7'h06: begin dec_nib = 4'd1; dec_val = 1'b1; end
            7'h5B: begin dec_nib = 4'd2; dec_val = 1'b1; end
            7'h4F: begin dec_nib = 4'd3; dec_val = 1'b1; end
            7'h66: begin dec_nib = 4'd4; dec_val = 1'b1; end
            7'h6D: begin dec_nib = 4'd5; dec_val = 1'b1; end
            7'h7D: begin dec_nib = 4'd6; dec_val = 1'b1; end
            7'h07: begin dec_nib = 4'd7; dec_val = 1'b1; end
            7'h7F: begin dec_nib = 4'd8; dec_val = 1'b1; end
            7'h6F: begin dec_nib = 4'd9; dec_val = 1'b1; end
            7'h00: begin dec_nib = 4'hF; end
            default: begin dec_nib = 4'hE; dec_bad = 1'b1; end
        endcase
    end

    // Idle counter saturates at TIMEOUT. The timeout event fires only on the
    // step that reaches TIMEOUT.
    assign timeout_evt = !capture && (idle_cnt == IDLE_PRE);

    always_ff @(posedge clk_osc or posedge reset) begin
        if (reset)
            idle_cnt <= '0;
        else if (capture)
            idle_cnt <= '0;
        else if (idle_cnt != IDLE_MAX)
            idle_cnt <= idle_cnt + 1'b1;
    end

    always_ff @(posedge clk_osc or posedge reset) begin
        if (reset) begin
            shadow_nib <= '1;
            shadow_val <= '0;
            shadow_on  <= '0;
        end else if (capture) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (pos_bit[i]) begin
                    shadow_nib[i*4 +: 4] <= dec_nib;
                    shadow_val[i]        <= dec_val;
                    shadow_on[i]         <= (seg_on == 7'h7F);
                end
            end
        end
    end

    always_ff @(posedge clk_osc or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            mask         <= '0;
            digits       <= '1;
            digit_valid  <= '0;
            frame_valid  <= 1'b0;
            frame_strobe <= 1'b0;
            alarm_lit    <= 1'b0;
            bad_code     <= 1'b0;
            onehot_err   <= 1'b0;
            stale        <= 1'b0;
        end else begin
            frame_strobe <= 1'b0;
            stale        <= 1'b0;
            bad_code     <= capture && dec_bad;
            onehot_err   <= event_fire && anode_multi;
            case (state)
                ST_COMMIT: begin
                    // The shadow is read before this cycle's capture lands.
                    // A capture in this cycle starts the next frame.
                    digits       <= shadow_nib;
                    digit_valid  <= shadow_val;
                    alarm_lit    <= &shadow_on;
                    frame_valid  <= 1'b1;
                    frame_strobe <= 1'b1;
                    if (capture) begin
                        mask  <= pos_bit;
                        state <= ST_COLLECT;
                    end else begin
                        mask  <= '0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    if (capture) begin
                        mask  <= mask_or;
                        state <= (mask_or == 4'b1111) ? ST_COMMIT : ST_COLLECT;
                    end else if (timeout_evt) begin
                        frame_valid <= 1'b0;
                        if (state == ST_COLLECT) begin
                            mask  <= '0;
                            stale <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder
//   Directed test of seg_scan_decoder with STABLE_CYCLES=4 and TIMEOUT=64.
//   Inputs are driven on the falling edge. Outputs are sampled on the falling edge.
//   A monitor counts the high cycles of each pulse output. Scenarios compare
//   the change in those counts against hand-computed values.
module tb_seg_scan_decoder;

    logic        clk_osc;
    logic        reset;
    logic [3:0]  anode;
    logic [6:0]  eseg;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic        frame_valid;
    logic        frame_strobe;
    logic        bad_code;
    logic        onehot_err;
    logic        alarm_lit;
    logic        stale;

    int n_vec = 0;
    int n_err = 0;
    int cnt_strobe = 0;
    int cnt_bad = 0;
    int cnt_onehot = 0;
    int cnt_stale = 0;

    seg_scan_decoder #(
        .STABLE_CYCLES(4),
        .TIMEOUT(64)
    ) dut (
        .clk_osc(clk_osc),
        .reset(reset),
        .anode(anode),
        .eseg(eseg),
        .digits(digits),
        .digit_valid(digit_valid),
        .frame_valid(frame_valid),
        .frame_strobe(frame_strobe),
        .bad_code(bad_code),
        .onehot_err(onehot_err),
        .alarm_lit(alarm_lit),
        .stale(stale)
    );

    initial clk_osc = 1'b0;
    always #5 clk_osc = ~clk_osc;

    always @(negedge clk_osc) begin
        if (frame_strobe) cnt_strobe = cnt_strobe + 1;
        if (bad_code)     cnt_bad    = cnt_bad + 1;
        if (onehot_err)   cnt_onehot = cnt_onehot + 1;
        if (stale)        cnt_stale  = cnt_stale + 1;
    end

    // Active-low eseg codes (inverse of the a..g glyph).
    localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30;
    localparam logic [6:0] S4 = 7'h19, S5 = 7'h12, S7 = 7'h78;
    localparam logic [6:0] S8 = 7'h00, S9 = 7'h10, SBLANK = 7'h7F, SBAD = 7'h36;
    localparam logic [3:0] A3 = 4'b1011, A2 = 4'b1101, A1 = 4'b1110, A0 = 4'b0111;
    localparam logic [3:0] AOFF = 4'b1111;

    task automatic hold(input logic [3:0] a, input logic [6:0] e, input int n);
        @(negedge clk_osc);
        anode = a;
        eseg  = e;
        repeat (n) @(posedge clk_osc);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        anode = AOFF;
        eseg  = SBLANK;
        repeat (3) @(posedge clk_osc);
        @(negedge clk_osc);
        n_vec++;
        if (digits !== 16'hFFFF) begin n_err++; $display("FAIL reset_digits got %h want ffff", digits); end
        n_vec++;
        if ({digit_valid, frame_valid, alarm_lit} !== 6'b0) begin
            n_err++; $display("FAIL reset_flags got %b want 000000", {digit_valid, frame_valid, alarm_lit});
        end
        n_vec++;
        if ({frame_strobe, bad_code, onehot_err, stale} !== 4'b0) begin
            n_err++; $display("FAIL reset_pulses got %b want 0000", {frame_strobe, bad_code, onehot_err, stale});
        end
        reset = 1'b0;
        hold(AOFF, SBLANK, 10);
        n_vec++;
        if (cnt_strobe !== 0 || digits !== 16'hFFFF) begin
            n_err++; $display("FAIL post_reset_idle strobes %0d digits %h want 0 ffff", cnt_strobe, digits);
        end
    endtask

    task automatic test_frame;
        int s0;
        s0 = cnt_strobe;
        hold(A3, S1, 10);
        hold(A2, S2, 10);
        hold(A1, S3, 10);
        hold(A0, S4, 10);
        hold(AOFF, SBLANK, 10);
        @(negedge clk_osc);
        n_vec++;
        if (cnt_strobe - s0 !== 1) begin n_err++; $display("FAIL frame_strobes got %0d want 1", cnt_strobe - s0); end
        n_vec++;
        if (digits !== 16'h1234) begin n_err++; $display("FAIL frame_digits got %h want 1234", digits); end
        n_vec++;
        if (digit_valid !== 4'hF || frame_valid !== 1'b1 || alarm_lit !== 1'b0) begin
            n_err++; $display("FAIL frame_flags got dv=%h fv=%b al=%b want f 1 0", digit_valid, frame_valid, alarm_lit);
        end
    endtask

    task automatic test_idle_timeout;
        int t0;
        t0 = cnt_stale;
        hold(AOFF, SBLANK, 70);
        @(negedge clk_osc);
        n_vec++;
        if (frame_valid !== 1'b0 || cnt_stale - t0 !== 0 || digits !== 16'h1234) begin
            n_err++; $display("FAIL idle_timeout got fv=%b stale=%0d digits=%h want 0 0 1234",
                              frame_valid, cnt_stale - t0, digits);
        end
    endtask

    task automatic test_alarm;
        hold(A3, S8, 10);
        hold(A2, S8, 10);
        hold(A1, S8, 10);
        hold(A0, S8, 10);
        hold(AOFF, SBLANK, 10);
        @(negedge clk_osc);
        n_vec++;
        if (digits !== 16'h8888 || alarm_lit !== 1'b1 || digit_valid !== 4'hF) begin
            n_err++; $display("FAIL alarm_on got digits=%h al=%b dv=%h want 8888 1 f", digits, alarm_lit, digit_valid);
        end
        hold(A3, S0, 10);
        hold(A2, S0, 10);
        hold(A1, S0, 10);
        hold(A0, S0, 10);
        hold(AOFF, SBLANK, 10);
        @(negedge clk_osc);
        n_vec++;
        if (digits !== 16'h0000 || alarm_lit !== 1'b0) begin
            n_err++; $display("FAIL alarm_off got digits=%h al=%b want 0000 0", digits, alarm_lit);
        end
    endtask

    task automatic test_glitch_bad;
        int b0;
        b0 = cnt_bad;
        // Three-cycle glitch: never stable long enough to capture.
        hold(A3, SBAD, 3);
        hold(AOFF, SBLANK, 12);
        @(negedge clk_osc);
        n_vec++;
        if (cnt_bad - b0 !== 0) begin n_err++; $display("FAIL glitch3_bad got %0d want 0", cnt_bad - b0); end
        // Four-cycle hold: the capture lands on the sixth rising edge.
        anode = A3;
        eseg  = SBAD;
        repeat (4) @(posedge clk_osc);
        @(negedge clk_osc);
        anode = AOFF;
        eseg  = SBLANK;
        @(posedge clk_osc);
        @(negedge clk_osc);
        n_vec++;
        if (bad_code !== 1'b0) begin n_err++; $display("FAIL hold4_early got %b want 0", bad_code); end
        @(posedge clk_osc);
        @(negedge clk_osc);
        n_vec++;
        if (bad_code !== 1'b1) begin n_err++; $display("FAIL hold4_capture got %b want 1", bad_code); end
        hold(AOFF, SBLANK, 8);
        hold(A2, S2, 10);
        hold(A1, S3, 10);
        hold(A0, S4, 10);
        hold(AOFF, SBLANK, 10);
        @(negedge clk_osc);
        n_vec++;
        if (digits !== 16'hE234 || digit_valid !== 4'b0111 || cnt_bad - b0 !== 1) begin
            n_err++; $display("FAIL bad_frame got digits=%h dv=%b bad=%0d want e234 0111 1",
                              digits, digit_valid, cnt_bad - b0);
        end
    endtask

    task automatic test_onehot;
        int o0, s0;
        o0 = cnt_onehot;
        s0 = cnt_strobe;
        hold(A3, S9, 10);
        @(negedge clk_osc);
        anode = 4'b0011;
        eseg  = S1;
        repeat (5) @(posedge clk_osc);
        @(negedge clk_osc);
        n_vec++;
        if (onehot_err !== 1'b0) begin n_err++; $display("FAIL onehot_early got %b want 0", onehot_err); end
        @(posedge clk_osc);
        @(negedge clk_osc);
        n_vec++;
        if (onehot_err !== 1'b1) begin n_err++; $display("FAIL onehot_pulse got %b want 1", onehot_err); end
        repeat (6) @(posedge clk_osc);
        // All anodes high with lit segments: neither a capture nor an error.
        hold(AOFF, S1, 10);
        hold(A2, S0, 10);
        hold(A1, S1, 10);
        hold(A0, S2, 10);
        hold(AOFF, SBLANK, 10);
        @(negedge clk_osc);
        n_vec++;
        if (cnt_onehot - o0 !== 1) begin n_err++; $display("FAIL onehot_count got %0d want 1", cnt_onehot - o0); end
        n_vec++;
        if (digits !== 16'h9012 || digit_valid !== 4'hF || cnt_strobe - s0 !== 1) begin
            n_err++; $display("FAIL onehot_frame got digits=%h dv=%h strobes=%0d want 9012 f 1",
                              digits, digit_valid, cnt_strobe - s0);
        end
    endtask

    task automatic test_timeout;
        int t0, s0;
        t0 = cnt_stale;
        s0 = cnt_strobe;
        hold(A3, S3, 10);
        hold(A2, S4, 10);
        hold(A1, S5, 10);
        @(negedge clk_osc);
        n_vec++;
        if (frame_valid !== 1'b1) begin n_err++; $display("FAIL pre_timeout_fv got %b want 1", frame_valid); end
        hold(AOFF, SBLANK, 80);
        @(negedge clk_osc);
        n_vec++;
        if (cnt_stale - t0 !== 1 || frame_valid !== 1'b0) begin
            n_err++; $display("FAIL timeout got stale=%0d fv=%b want 1 0", cnt_stale - t0, frame_valid);
        end
        n_vec++;
        if (digits !== 16'h9012 || cnt_strobe - s0 !== 0) begin
            n_err++; $display("FAIL timeout_retain got digits=%h strobes=%0d want 9012 0", digits, cnt_strobe - s0);
        end
    endtask

    task automatic test_reset_midframe;
        int s0;
        hold(A0, S4, 10);
        hold(A1, S3, 10);
        @(negedge clk_osc);
        reset = 1'b1;
        anode = AOFF;
        eseg  = SBLANK;
        #1;
        n_vec++;
        if (digits !== 16'hFFFF || frame_valid !== 1'b0 || digit_valid !== 4'h0) begin
            n_err++; $display("FAIL midframe_reset got digits=%h fv=%b dv=%h want ffff 0 0",
                              digits, frame_valid, digit_valid);
        end
        repeat (3) @(posedge clk_osc);
        @(negedge clk_osc);
        reset = 1'b0;
        s0 = cnt_strobe;
        hold(A3, S1, 10);
        hold(A2, S2, 10);
        hold(AOFF, SBLANK, 10);
        @(negedge clk_osc);
        n_vec++;
        if (cnt_strobe - s0 !== 0) begin
            n_err++; $display("FAIL partial_after_reset got strobes=%0d want 0", cnt_strobe - s0);
        end
        hold(A1, S3, 10);
        hold(A0, S4, 10);
        hold(AOFF, SBLANK, 10);
        @(negedge clk_osc);
        n_vec++;
        if (cnt_strobe - s0 !== 1 || digits !== 16'h1234) begin
            n_err++; $display("FAIL fresh_frame got strobes=%0d digits=%h want 1 1234", cnt_strobe - s0, digits);
        end
    endtask

    initial begin
        test_reset;
        test_frame;
        test_idle_timeout;
        test_alarm;
        test_glitch_bad;
        test_onehot;
        test_timeout;
        test_reset_midframe;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
